// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and data access, with alternating priority and a per-access watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_ready_q, d_ready_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic: arbitration, access tracking, watchdog abort.
  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    cnt_d         = cnt_q;
    if_rdata_d    = if_rdata_q;
    if_ready_d    = 1'b0;
    d_rdata_d     = d_rdata_q;
    d_ready_d     = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_req && (!if_req || !last_d_q)) begin
          state_d     = BUSY_D;
          last_d_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (if_req) begin
          state_d     = BUSY_I;
          last_d_d    = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_ready_d = 1'b1;
          end
        end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
          state_d       = RESP;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          if (state_q == BUSY_I) begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        mem_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b0;
      cnt_q         <= '0;
      if_rdata_q    <= '0;
      if_ready_q    <= 1'b0;
      d_rdata_q     <= '0;
      d_ready_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      cnt_q         <= cnt_d;
      if_rdata_q    <= if_rdata_d;
      if_ready_q    <= if_ready_d;
      d_rdata_q     <= d_rdata_d;
      d_ready_q     <= d_ready_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ready    = if_ready_q;
  assign d_rdata     = d_rdata_q;
  assign d_ready     = d_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a
// scoreboard of expected ready pulses in completion order.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t    sb[$];
  sb_item_t    mon_item;
  int          checks = 0;
  int          failures = 0;
  int          ack_delay = 2;
  int          wait_cnt = 0;
  bit          ack_sent = 0;
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] exp_d;
  int          n;
  int          got;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memVal(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iq, input logic [31:0] ia, input logic dq,
                               input logic dw, input logic [31:0] da, input logic [31:0] dd);
    if_req  = iq;
    if_addr = ia;
    d_req   = dq;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic waitReady(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(if_ready || d_ready) && cycles < limit);
    checkOutput("ready_seen", 64'(if_ready || d_ready), 64'd1);
  endtask

  // Behavioural memory: acks ack_delay cycles after mem_req is first seen; -1 never acks.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!mem_req) begin
      wait_cnt = 0;
      ack_sent = 0;
    end else if (!ack_sent) begin
      if (wait_cnt == ack_delay) begin
        mem_ack  = 1'b1;
        ack_sent = 1;
        if (mem_we) begin
          mem_store[mem_addr] = mem_wdata;
          mem_rdata = 32'hDEAD_BEEF;
        end else begin
          mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : memVal(mem_addr);
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Scoreboard monitor: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_ready || d_ready) begin
      checkOutput("single_ready", 64'(if_ready && d_ready), 64'd0);
      checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_item = sb.pop_front();
        checkOutput("ready_who", 64'(d_ready), 64'(mon_item.is_d));
        checkOutput("ready_rdata", 64'(mon_item.is_d ? d_rdata : if_rdata), 64'(mon_item.data));
      end
    end
  end

  // Global guard so the run always ends.
  initial begin
    #60000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  // Directed sequence of steps.
  initial begin
    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_store[32'h40] = 32'h2008_0005;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_if_rdata", 64'(if_rdata), 64'd0);
    checkOutput("rst_d_rdata", 64'(d_rdata), 64'd0);
    checkOutput("rst_timeout", 64'(timeout_err), 64'd0);
    checkOutput("rst_if_ready", 64'(if_ready), 64'd0);

    // Single fetch granted on the first cycle out of reset.
    ack_delay = 2;
    sb.push_back('{1'b0, 32'h2008_0005});
    reset = 1'b1;
    @(negedge clk);
    checkOutput("fetch_mem_req", 64'(mem_req), 64'd1);
    checkOutput("fetch_mem_we", 64'(mem_we), 64'd0);
    checkOutput("fetch_mem_addr", 64'(mem_addr), 64'h40);
    checkOutput("fetch_busy", 64'(busy), 64'd1);
    waitReady(20, n);
    checkOutput("fetch_latency", 64'(n + 1), 64'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Contention from reset release: D, I, D, I.
    reset = 1'b0;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
    repeat (2) @(negedge clk);
    ack_delay = 1;
    sb.push_back('{1'b1, memVal(32'h200)});
    sb.push_back('{1'b0, memVal(32'h100)});
    sb.push_back('{1'b1, memVal(32'h200)});
    sb.push_back('{1'b0, memVal(32'h100)});
    reset = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge clk);
      if (if_ready || d_ready) got++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("contention_count", 64'(got), 64'd4);
    exp_d = memVal(32'h200);
    @(negedge clk);

    // Store leaves d_rdata alone, then load it back.
    ack_delay = 2;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hCAFE_F00D);
    sb.push_back('{1'b1, exp_d});
    @(negedge clk);
    checkOutput("store_mem_req", 64'(mem_req), 64'd1);
    checkOutput("store_mem_we", 64'(mem_we), 64'd1);
    checkOutput("store_mem_addr", 64'(mem_addr), 64'h80);
    checkOutput("store_mem_wdata", 64'(mem_wdata), 64'hCAFE_F00D);
    waitReady(20, n);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    sb.push_back('{1'b1, 32'hCAFE_F00D});
    waitReady(20, n);
    checkOutput("load_latency", 64'(n), 64'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Ack arrives in the fifteenth busy cycle: normal completion.
    ack_delay = 14;
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
    sb.push_back('{1'b0, memVal(32'h300)});
    waitReady(40, n);
    checkOutput("late_ack_latency", 64'(n), 64'd16);
    checkOutput("late_ack_no_timeout", 64'(timeout_err), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Watchdog abort on a load that is never acked.
    ack_delay = -1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0);
    sb.push_back('{1'b1, 32'h0});
    waitReady(40, n);
    checkOutput("abort_latency", 64'(n), 64'd16);
    checkOutput("abort_timeout", 64'(timeout_err), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("abort_idle_mem_req", 64'(mem_req), 64'd0);

    // A good access afterwards keeps the sticky flag.
    ack_delay = 0;
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0);
    sb.push_back('{1'b0, memVal(32'h500)});
    waitReady(20, n);
    checkOutput("fast_latency", 64'(n), 64'd2);
    checkOutput("sticky_timeout", 64'(timeout_err), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Reset in the middle of a busy access abandons it.
    ack_delay = -1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("midrst_pre_mem_req", 64'(mem_req), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_d_ready", 64'(d_ready), 64'd0);
    checkOutput("midrst_timeout", 64'(timeout_err), 64'd0);
    checkOutput("midrst_if_rdata", 64'(if_rdata), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    repeat (6) @(negedge clk);
    checkOutput("post_busy", 64'(busy), 64'd0);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
